// File: rtl/delay_arbiter_if.sv
// Request/grant bundle between the game controllers and the shared delay timer.
// The master side drives requests and abort; the slave side is the arbiter.
interface delay_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int CNT_W = 12
);
  logic [N_REQ-1:0] i_Req;
  logic             i_Abort;
  logic [N_REQ-1:0] o_Grant;
  logic [N_REQ-1:0] o_Done;
  logic             o_Busy;
  logic [CNT_W-1:0] o_Count;

  modport master (
    output i_Req, i_Abort,
    input  o_Grant, o_Done, o_Busy, o_Count
  );

  modport slave (
    input  i_Req, i_Abort,
    output o_Grant, o_Done, o_Busy, o_Count
  );
endinterface

// File: rtl/delay_arbiter.sv
// Round-robin owner of the single game delay: times TICKS x DIV clk_50M cycles
// for one requester at a time, using an internal prescaler instead of a 2 kHz clock.
module delay_arbiter #(
  parameter int N_REQ = 3,
  parameter int DIV   = 25000,
  parameter int TICKS = 4000,
  parameter int CNT_W = 12
) (
  input  logic             clk_50M,
  input  logic             i_Reset_n,
  delay_arbiter_if.slave   bus
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_cur;
  logic [PW-1:0]    r_presc;
  logic [CNT_W-1:0] r_count;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_done;
  logic             r_busy;

  logic             w_found;
  logic [IW-1:0]    w_win;
  logic [IW-1:0]    w_cur_next;
  logic             w_abort;
  logic             w_wrap;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(r_ptr) + k) % N_REQ;
      if (!w_found && bus.i_Req[idx]) begin
        w_found = 1'b1;
        w_win   = IW'(idx);
      end
    end
  end

  assign w_cur_next = (r_cur == IW'(N_REQ - 1)) ? '0 : r_cur + 1'b1;
  assign w_abort    = bus.i_Abort || !bus.i_Req[r_cur];
  assign w_wrap     = (r_presc == PW'(DIV - 1));

  always_ff @(posedge clk_50M or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cur   <= '0;
      r_presc <= '0;
      r_count <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= '0;
          if (w_found) begin
            r_state <= S_RUN;
            r_cur   <= w_win;
            r_grant <= N_REQ'(1) << w_win;
            r_presc <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          // Abort wins over a completion falling on the same edge.
          if (w_abort) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_count <= '0;
            r_presc <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_cur_next;
          end else if (w_wrap) begin
            r_presc <= '0;
            r_count <= r_count + 1'b1;
            if (r_count == CNT_W'(TICKS - 1)) begin
              r_state <= S_DONE;
              r_done  <= N_REQ'(1) << r_cur;
              r_ptr   <= w_cur_next;
            end
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_done  <= '0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_Grant = r_grant;
  assign bus.o_Done  = r_done;
  assign bus.o_Busy  = r_busy;
  assign bus.o_Count = r_count;
endmodule

// File: tb/tb_delay_arbiter.sv
// Directed bench for delay_arbiter with DIV=4, TICKS=3 so one delay is 12 cycles.
module tb_delay_arbiter;
  localparam int N_REQ = 3;
  localparam int DIV   = 4;
  localparam int TICKS = 3;
  localparam int CNT_W = 4;

  logic clk_50M;
  logic i_Reset_n;
  int   checks;
  int   failures;

  delay_arbiter_if #(.N_REQ(N_REQ), .CNT_W(CNT_W)) bus ();

  delay_arbiter #(
    .N_REQ(N_REQ), .DIV(DIV), .TICKS(TICKS), .CNT_W(CNT_W)
  ) dut (
    .clk_50M  (clk_50M),
    .i_Reset_n(i_Reset_n),
    .bus      (bus.slave)
  );

  initial clk_50M = 1'b0;
  always #5 clk_50M = ~clk_50M;

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] g, input logic [2:0] d,
                         input logic b, input logic [3:0] c);
    chk({tag, "_grant"}, 32'(bus.o_Grant), 32'(g));
    chk({tag, "_done"},  32'(bus.o_Done),  32'(d));
    chk({tag, "_busy"},  32'(bus.o_Busy),  32'(b));
    chk({tag, "_count"}, 32'(bus.o_Count), 32'(c));
  endtask

  // Grant has just risen; run 12 cycles and check count steps and the done pulse.
  task automatic run_full(input string tag, input logic [2:0] g);
    for (int c = 1; c <= DIV * TICKS; c++) begin
      tick();
      chk_all(tag, g, (c == DIV * TICKS) ? g : 3'b000, 1'b1, 4'(c / DIV));
    end
    $display("txn %s grant=%b done=%b count=%0d", tag, bus.o_Grant, bus.o_Done, bus.o_Count);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    i_Reset_n   = 1'b0;
    bus.i_Req   = '0;
    bus.i_Abort = 1'b0;
    tick();
    tick();
    chk_all("reset", 3'b000, 3'b000, 1'b0, 4'd0);

    // Single request, full delay.
    i_Reset_n = 1'b1;
    tick();
    bus.i_Req = 3'b001;
    tick();
    chk_all("grant0", 3'b001, 3'b000, 1'b1, 4'd0);
    run_full("single0", 3'b001);
    bus.i_Req = 3'b000;
    tick();
    chk_all("after_done", 3'b000, 3'b000, 1'b0, 4'd3);

    // Asynchronous reset in the middle of RUN.
    bus.i_Req = 3'b001;
    tick();
    chk_all("regrant0", 3'b001, 3'b000, 1'b1, 4'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("mid_run_count", 32'(bus.o_Count), 32'd1);
    #2 i_Reset_n = 1'b0;
    #1;
    chk_all("async_reset", 3'b000, 3'b000, 1'b0, 4'd0);
    $display("txn async_reset grant=%b busy=%b", bus.o_Grant, bus.o_Busy);
    bus.i_Req = 3'b000;
    tick();
    i_Reset_n = 1'b1;
    tick();

    // Round-robin with all three requesting continuously.
    bus.i_Req = 3'b111;
    tick();
    for (int gi = 0; gi < 4; gi++) begin
      logic [2:0] exp_g;
      exp_g = 3'(1 << (gi % 3));
      chk("rr_grant", 32'(bus.o_Grant), 32'(exp_g));
      run_full("rr", exp_g);
      if (gi == 3) bus.i_Req = 3'b000;
      tick();
      chk_all("rr_idle", 3'b000, 3'b000, 1'b0, 4'd3);
      if (gi < 3) tick();
    end

    // Requester withdraws mid-delay; pointer moves past it.
    i_Reset_n = 1'b0;
    tick();
    i_Reset_n = 1'b1;
    bus.i_Req = 3'b001;
    tick();
    chk("wd_grant", 32'(bus.o_Grant), 32'b001);
    for (int i = 0; i < 5; i++) tick();
    bus.i_Req = 3'b000;
    tick();
    chk_all("withdraw", 3'b000, 3'b000, 1'b0, 4'd0);
    $display("txn withdraw grant=%b count=%0d", bus.o_Grant, bus.o_Count);
    bus.i_Req = 3'b011;
    tick();
    chk_all("wd_next", 3'b010, 3'b000, 1'b1, 4'd0);

    // Abort on the edge that would complete the delay.
    for (int i = 0; i < DIV * TICKS - 1; i++) tick();
    chk_all("pre_abort", 3'b010, 3'b000, 1'b1, 4'd2);
    bus.i_Abort = 1'b1;
    tick();
    chk_all("abort_done_edge", 3'b000, 3'b000, 1'b0, 4'd0);
    $display("txn abort grant=%b done=%b", bus.o_Grant, bus.o_Done);
    bus.i_Req = 3'b000;
    tick();
    chk("abort_idle_grant", 32'(bus.o_Grant), 32'd0);

    // Abort is ignored in IDLE: a request still wins.
    bus.i_Req = 3'b100;
    tick();
    chk_all("abort_in_idle", 3'b100, 3'b000, 1'b1, 4'd0);
    bus.i_Abort = 1'b0;

    // Slow drop after done: lone requester is re-granted.
    run_full("slow2", 3'b100);
    tick();
    chk_all("slow_idle", 3'b000, 3'b000, 1'b0, 4'd3);
    tick();
    chk_all("slow_regrant", 3'b100, 3'b000, 1'b1, 4'd0);

    // Slow drop with another request pending: the other one wins.
    run_full("slow2b", 3'b100);
    bus.i_Req = 3'b101;
    tick();
    chk("slow_idle2", 32'(bus.o_Grant), 32'd0);
    tick();
    chk_all("pending_wins", 3'b001, 3'b000, 1'b1, 4'd0);
    $display("txn pending_wins grant=%b", bus.o_Grant);
    bus.i_Req = 3'b000;
    tick();
    chk("final_release", 32'(bus.o_Grant), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/delay_arbiter.md
# delay_arbiter

Shares the single 2-second game delay between the BlackJack controllers, for example dealer-draw pause, card-reveal hold and result-display hold. Each requester asks for one delay. The block grants one requester at a time in round-robin order and times exactly TICKS × DIV cycles of clk_50M. It exposes the elapsed tick count for the display path. It replaces the separate 2 kHz clock with an internal prescaler enable, so the whole block runs on one clock.

## Interface
Parameters:
- N_REQ, 3, number of requesters (≥2)
- DIV, 25000, clk_50M cycles per tick (50 MHz → 2 kHz)
- TICKS, 4000, ticks per delay (4000 × 0.5 ms = 2 s)
- CNT_W, 12, width of o_Count; must satisfy 2^CNT_W > TICKS

Ports:
- clk_50M  in  1  50 MHz system clock; the only clock
- i_Reset_n  in  1  asynchronous, active-low reset
- i_Req  in  N_REQ  level request per requester; held high until o_Done
- i_Abort  in  1  cancels the running delay
- o_Grant  out  N_REQ  one-hot; the bit is high while that requester's delay runs
- o_Done  out  N_REQ  one-cycle pulse to the served requester at delay completion
- o_Busy  out  1  high in RUN and DONE
- o_Count  out  CNT_W  ticks elapsed in the current delay

## Operation
- **States:**
  - IDLE: no grant.
  - RUN: timing.
  - DONE: single-cycle completion.
- **IDLE → RUN:** taken on the first edge where any i_Req bit is high.
  - Winner: first requesting index at or after pointer `ptr`, searching upward and wrapping modulo N_REQ.
  - At that edge:
    - o_Grant gets the winner's one-hot.
    - The prescaler and o_Count clear to 0.
    - Winner index is stored as `cur`.
- **RUN:**
  - Prescaler counts 0..DIV-1 and wraps to 0.
  - o_Count increments on each wrap.
  - On the wrap where o_Count == TICKS-1:
    - o_Count becomes TICKS.
    - State → DONE.
- **DONE:**
  - o_Done[cur] = 1.
  - o_Grant stays high.
  - `ptr` ← (cur+1) mod N_REQ.
  - Next edge: → IDLE, o_Grant = 0. o_Count holds TICKS until the next grant.
- **Abort from RUN:** taken when i_Abort = 1 or i_Req[cur] = 0.
  - Next edge: → IDLE, o_Grant = 0, o_Count = 0.
  - No o_Done pulse.
  - `ptr` ← (cur+1) mod N_REQ.
  - Abort takes precedence over completion on the same edge.
- **i_Abort outside RUN:** ignored in IDLE and DONE.
- **Request changes during RUN:** requests from non-granted requesters rise or fall freely. They are only evaluated in IDLE.
- **Requester rule:** drop i_Req on the edge after seeing o_Done.
  - A request still high in IDLE is treated as a new request.
  - Because `ptr` has advanced past it, the requester only wins if no other request is pending.
- **Width rules:**
  - Prescaler width is ceil(log2(DIV)).
  - o_Count never exceeds TICKS and never wraps.
- **Reset (i_Reset_n low, asynchronous, any state including mid-RUN):**
  - State = IDLE, ptr = 0.
  - o_Grant = 0, o_Done = 0, o_Busy = 0, o_Count = 0, prescaler = 0.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- **Request to grant:** i_Req high before edge k → o_Grant high after edge k.
- **Grant to done:** o_Done rises exactly DIV × TICKS cycles after o_Grant rises (100,000,000 cycles at defaults). It stays high for 1 cycle.
- **o_Grant:** falls 1 cycle after o_Done rises.
- **Back-to-back service:** earliest next grant is 2 cycles after o_Done rises (DONE → IDLE → RUN).
- **Abort latency:** o_Grant falls 1 edge after i_Abort is sampled high.

## Test plan
Run with DIV=4, TICKS=3, N_REQ=3, so a delay is 12 cycles.

1. **Reset:** assert i_Reset_n=0 mid-RUN → all outputs are 0 immediately, without waiting for a clock edge. Release, raise i_Req=3'b001 → o_Grant=001 one cycle later. o_Done[0] pulses 12 cycles after the grant. o_Count steps 0,1,2,3.
2. **Round-robin:** hold i_Req=3'b111 continuously → grant sequence 001, 010, 100, 001. Each grant lasts 13 cycles (12 in RUN plus 1 in DONE), with 1 IDLE cycle between grants.
3. **Requester withdraws:** raise i_Req=001, drop it after 5 cycles → grant falls next edge, no o_Done, o_Count = 0. Then raise i_Req=011 → grant 010, because ptr advanced.
4. **i_Abort on the completion edge:** assert i_Abort on the edge where o_Count would reach 3 → no o_Done, IDLE, o_Count = 0.
5. **Slow drop after o_Done:** single requester 100 keeps i_Req high for one extra cycle after o_Done → it is re-granted. Then repeat with 001 also pending → 001 wins.
6. **Default parameters:** with DIV=25000, TICKS=4000, check that o_Done rises exactly 100,000,000 cycles after o_Grant, using a cycle counter.
